div_mae_monitor: RTL

Sequential error monitor that sits directly downstream of the combinational 16/8 approximate array divider. It accepts each operand pair together with the approximate quotient and remainder, and recomputes the exact result with an internal one-bit-per-cycle restoring divider. It accumulates mean-absolute-error statistics (sample count, error sum, maximum error, out-of-range count) for readout by the characterisation harness.

---
 rtl/div_mae_pkg.sv | 17 +
 rtl/div_restoring_seq.sv | 70 +++++++
 rtl/div_mae_monitor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/div_mae_pkg.sv
// Shared widths, FSM state encoding and helpers for the divider error monitor.
package div_mae_pkg;

    localparam int DW_N = 16;
    localparam int DW_D = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        ACC  = 2'd2
    } state_t;

    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/div_restoring_seq.sv
// 16/8 restoring divider, one quotient bit per cycle: start pulse loads operands,
// done pulses during the eighth step, q/r hold their final values afterwards.
module div_restoring_seq
    import div_mae_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [DW_N-1:0] n,
    input  logic [DW_D-1:0] d,
    output logic            done,
    output logic [DW_D-1:0] q,
    output logic [DW_D-1:0] r
);

    logic [DW_D:0]   rem;
    logic [DW_D-1:0] n_lo;
    logic [DW_D-1:0] d_q;
    logic [DW_D-1:0] q_sh;
    logic [2:0]      step;
    logic            running;

    logic [DW_D:0]   rem_sh;
    logic [DW_D:0]   rem_sub;
    logic            ge;
    logic            unused_rem_msb;

    always_comb begin
        rem_sh  = {rem[DW_D-1:0], n_lo[DW_D-1]};
        ge      = (rem_sh >= {1'b0, d_q});
        rem_sub = rem_sh - {1'b0, d_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem     <= '0;
            n_lo    <= '0;
            d_q     <= '0;
            q_sh    <= '0;
            step    <= '0;
            running <= 1'b0;
        end else if (abort) begin
            running <= 1'b0;
            step    <= '0;
        end else if (start) begin
            rem     <= {1'b0, n[DW_N-1:DW_D]};
            n_lo    <= n[DW_D-1:0];
            d_q     <= d;
            q_sh    <= '0;
            step    <= '0;
            running <= 1'b1;
        end else if (running) begin
            rem     <= ge ? rem_sub : rem_sh;
            n_lo    <= {n_lo[DW_D-2:0], 1'b0};
            q_sh    <= {q_sh[DW_D-2:0], ge};
            step    <= step + 3'd1;
            if (step == 3'd7) begin
                running <= 1'b0;
            end
        end
    end

    // Quotient < 256 is guaranteed by the caller's range check, so rem never exceeds 8 bits.
    assign done           = running & (step == 3'd7);
    assign q              = q_sh;
    assign r              = rem[DW_D-1:0];
    assign unused_rem_msb = rem[DW_D];

endmodule

// File: rtl/div_mae_monitor.sv
// Mean-absolute-error monitor for the approximate 16/8 divider.
// Define DIV_MAE_REMAINDER_EN to also accumulate remainder error statistics.
module div_mae_monitor
    import div_mae_pkg::*;
#(
    parameter int SUM_W = 40,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW_N-1:0]  n,
    input  logic [DW_D-1:0]  d,
    input  logic [DW_D-1:0]  q_apx,
    input  logic [DW_D-1:0]  r_apx,
    input  logic             clear,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] range_cnt,
    output logic [SUM_W-1:0] err_sum,
    output logic [7:0]       err_max,
    output logic [SUM_W-1:0] rerr_sum,
    output logic [7:0]       rerr_max,
    output logic             sat,
    output state_t           fsm_state
);

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic            oor_in;
    logic            oor_q;
    logic [DW_D-1:0] qa_q;
    logic            div_start;
    logic            div_done;
    logic [DW_D-1:0] div_q;
    logic [DW_D-1:0] div_r;
    logic [7:0]      eq;
    logic            sat_now;
    logic            upd;

    assign in_ready  = (state == IDLE) & ~clear;
    assign busy      = (state != IDLE);
    assign fsm_state = state;
    assign accept    = in_valid & in_ready;
    assign oor_in    = (d == '0) | (n[DW_N-1:DW_D] >= d);
    assign eq        = abs_diff8(div_q, qa_q);
    assign sat_now   = sat | (sample_cnt == {CNT_W{1'b1}});
    assign upd       = (state == ACC) & ~oor_q & ~sat_now & ~clear;

    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    div_start  = ~oor_in;
                    state_next = oor_in ? ACC : DIV;
                end
            end
            DIV: begin
                if (div_done) begin
                    state_next = ACC;
                end
            end
            ACC:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    div_restoring_seq u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .abort (clear),
        .n     (n),
        .d     (d),
        .done  (div_done),
        .q     (div_q),
        .r     (div_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oor_q      <= 1'b0;
            qa_q       <= '0;
            sample_cnt <= '0;
            range_cnt  <= '0;
            err_sum    <= '0;
            err_max    <= '0;
            sat        <= 1'b0;
        end else if (clear) begin
            sample_cnt <= '0;
            range_cnt  <= '0;
            err_sum    <= '0;
            err_max    <= '0;
            sat        <= 1'b0;
        end else begin
            if (accept) begin
                oor_q <= oor_in;
                qa_q  <= q_apx;
            end
            if (sample_cnt == {CNT_W{1'b1}}) begin
                sat <= 1'b1;
            end
            if ((state == ACC) && oor_q && (range_cnt != {CNT_W{1'b1}})) begin
                range_cnt <= range_cnt + CNT_W'(1);
            end
            if (upd) begin
                sample_cnt <= sample_cnt + CNT_W'(1);
                err_sum    <= err_sum + SUM_W'(eq);
                if (eq > err_max) begin
                    err_max <= eq;
                end
            end
        end
    end

`ifdef DIV_MAE_REMAINDER_EN
    logic [DW_D-1:0] ra_q;
    logic [7:0]      er;

    assign er = abs_diff8(div_r, ra_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ra_q     <= '0;
            rerr_sum <= '0;
            rerr_max <= '0;
        end else if (clear) begin
            rerr_sum <= '0;
            rerr_max <= '0;
        end else begin
            if (accept) begin
                ra_q <= r_apx;
            end
            if (upd) begin
                rerr_sum <= rerr_sum + SUM_W'(er);
                if (er > rerr_max) begin
                    rerr_max <= er;
                end
            end
        end
    end
`else
    logic unused_rem;

    assign unused_rem = ^{r_apx, div_r};
    assign rerr_sum   = '0;
    assign rerr_max   = '0;
`endif

endmodule
